dp_ram_arbiter: RTL and testbench

//  Shares the two ports (A, B) of dp_ram among NUM_REQ requesters. Each cycle grants up to
//  two requests round-robin, first grant to port A, second to port B. Registers the RAM

---
 rtl/dp_ram_arb_pkg.sv | 37 +++
 rtl/dp_ram_arbiter_rr_pick.sv | 25 ++
 rtl/dp_ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dp_ram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_arb_pkg.sv
// rtl/dp_ram_arb_pkg.sv - shared types and round-robin search helper for dp_ram_arbiter
package dp_ram_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t id;
  } rd_tag_t;

  // Returns {found, index} of the first set bit of mask, scanning circularly
  // from start over the lowest n bits.
  function automatic logic [IDX_W:0] rr_next(input logic [MAX_REQ-1:0] mask,
                                             input idx_t start,
                                             input int n);
    logic found;
    idx_t idx;
    idx_t pos;
    int   j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(start) + k;
      if (j >= n) j = j - n;
      pos = idx_t'(j);
      if (!found && (k < n) && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/dp_ram_arbiter_rr_pick.sv
// rtl/dp_ram_arbiter_rr_pick.sv - circular first-set picker over N request bits
module rr_pick
  import dp_ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] mask_i,
  input  idx_t         start_i,
  output logic         found_o,
  output idx_t         idx_o
);

  logic [MAX_REQ-1:0] mask_wide;
  logic [IDX_W:0]     res;

  always_comb begin
    mask_wide         = '0;
    mask_wide[N-1:0]  = mask_i;
  end

  assign res     = rr_next(mask_wide, start_i, N);
  assign found_o = res[IDX_W];
  assign idx_o   = res[IDX_W-1:0];

endmodule

// File: rtl/dp_ram_arbiter.sv
// rtl/dp_ram_arbiter.sv - two-grant round-robin arbiter sharing dp_ram ports A/B
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
  output logic                             wrA,
  output logic [ADDR_WIDTH-1:0]            addrA,
  output logic [DATA_WIDTH-1:0]            dataA_in,
  input  logic [DATA_WIDTH-1:0]            dataA_out,
  output logic                             wrB,
  output logic [ADDR_WIDTH-1:0]            addrB,
  output logic [DATA_WIDTH-1:0]            dataB_in,
  input  logic [DATA_WIDTH-1:0]            dataB_out
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_num_req_check
    $error("dp_ram_arbiter: NUM_REQ must be in 2..16");
  end

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  function automatic idx_t wrap_inc(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  idx_t                  rr_ptr_q, rr_ptr_d;
  logic                  found0, found1;
  idx_t                  g0, g1;
  logic [NUM_REQ-1:0]    sel0, sel1_raw, sel1, mask1;
  logic                  wr0, wr1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  conflict, grant1;

  ram_cmd_t cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
  rd_tag_t  tag_a1_q, tag_a1_d, tag_a2_q;
  rd_tag_t  tag_b1_q, tag_b1_d, tag_b2_q;

  rr_pick #(.N(NUM_REQ)) u_pick0 (
    .mask_i  (req_valid),
    .start_i (rr_ptr_q),
    .found_o (found0),
    .idx_o   (g0)
  );

  // Searching from the same start with g0 removed yields the next valid after g0.
  assign mask1 = req_valid & ~sel0;

  rr_pick #(.N(NUM_REQ)) u_pick1 (
    .mask_i  (mask1),
    .start_i (rr_ptr_q),
    .found_o (found1),
    .idx_o   (g1)
  );

  always_comb begin
    sel0     = '0;
    sel1_raw = '0;
    wr0      = 1'b0;
    wr1      = 1'b0;
    addr0    = '0;
    addr1    = '0;
    wdata0   = '0;
    wdata1   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found0 && g0 == idx_t'(i)) begin
        sel0[i] = 1'b1;
        wr0     = req_wr[i];
        addr0   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata0  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (found1 && g1 == idx_t'(i)) begin
        sel1_raw[i] = 1'b1;
        wr1         = req_wr[i];
        addr1       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata1      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Same-address pairs involving a write are split across cycles; read/read may share.
  assign conflict  = found1 && (addr1 == addr0) && (wr0 || wr1);
  assign grant1    = found1 && !conflict;
  assign sel1      = grant1 ? sel1_raw : '0;
  assign req_ready = sel0 | sel1;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant1) begin
      rr_ptr_d = wrap_inc(g1);
    end else if (found0) begin
      rr_ptr_d = wrap_inc(g0);
    end
  end

  always_comb begin
    cmd_a_d    = cmd_a_q;
    cmd_a_d.wr = 1'b0;
    if (found0) begin
      cmd_a_d.wr    = wr0;
      cmd_a_d.addr  = addr0;
      cmd_a_d.wdata = wdata0;
    end
    cmd_b_d    = cmd_b_q;
    cmd_b_d.wr = 1'b0;
    if (grant1) begin
      cmd_b_d.wr    = wr1;
      cmd_b_d.addr  = addr1;
      cmd_b_d.wdata = wdata1;
    end
    tag_a1_d.valid = found0 && !wr0;
    tag_a1_d.id    = g0;
    tag_b1_d.valid = grant1 && !wr1;
    tag_b1_d.id    = g1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cmd_a_q  <= '0;
      cmd_b_q  <= '0;
      tag_a1_q <= '0;
      tag_a2_q <= '0;
      tag_b1_q <= '0;
      tag_b2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cmd_a_q  <= cmd_a_d;
      cmd_b_q  <= cmd_b_d;
      tag_a1_q <= tag_a1_d;
      tag_a2_q <= tag_a1_q;
      tag_b1_q <= tag_b1_d;
      tag_b2_q <= tag_b1_q;
    end
  end

  assign wrA      = cmd_a_q.wr;
  assign addrA    = cmd_a_q.addr;
  assign dataA_in = cmd_a_q.wdata;
  assign wrB      = cmd_b_q.wr;
  assign addrB    = cmd_b_q.addr;
  assign dataB_in = cmd_b_q.wdata;

  // Second tag stage lines up with the RAM's registered read data.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_a2_q.valid && tag_a2_q.id == idx_t'(i)) begin
        rsp_valid[i]                         = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = dataA_out;
      end
      if (tag_b2_q.valid && tag_b2_q.id == idx_t'(i)) begin
        rsp_valid[i]                         = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = dataB_out;
      end
    end
  end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// tb/tb_dp_ram_arbiter.sv - self-checking bench for dp_ram_arbiter with a behavioural dp_ram
module tb_dp_ram_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_wr, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata, rsp_rdata;
  logic              wrA, wrB;
  logic [AW-1:0]     addrA, addrB;
  logic [DW-1:0]     dataA_in, dataB_in, dataA_out, dataB_out;

  logic [DW-1:0] ram_mem   [16];
  logic [DW-1:0] model_mem [16];

  typedef struct {
    int          id;
    logic [7:0]  data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_cnt [NR];
  int mon_idx;

  dp_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wrA       (wrA),
    .addrA     (addrA),
    .dataA_in  (dataA_in),
    .dataA_out (dataA_out),
    .wrB       (wrB),
    .addrB     (addrB),
    .dataB_in  (dataB_in),
    .dataB_out (dataB_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wrA) ram_mem[addrA] <= dataA_in;
    if (wrB) ram_mem[addrB] <= dataB_in;
    dataA_out <= ram_mem[addrA];
    dataB_out <= ram_mem[addrB];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        mon_idx = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (mon_idx < 0 && exp_q[j].id == i) mon_idx = j;
        total++;
        if (mon_idx < 0) begin
          bad++;
          $display("FAIL rsp_unexpected: id=%0d data=%h cycle=%0d, required no response", i, rsp_rdata[i*DW +: DW], cyc);
        end else begin
          if (rsp_rdata[i*DW +: DW] !== exp_q[mon_idx].data || cyc != exp_q[mon_idx].due) begin
            bad++;
            $display("FAIL rsp_data id=%0d: got %h at cycle %0d, required %h at cycle %0d",
                     i, rsp_rdata[i*DW +: DW], cyc, exp_q[mon_idx].data, exp_q[mon_idx].due);
          end
          exp_q.delete(mon_idx);
          rsp_cnt[i]++;
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].due < cyc) begin
        total++;
        bad++;
        $display("FAIL rsp_missing id=%0d: no response by cycle %0d, required at cycle %0d", exp_q[j].id, cyc, exp_q[j].due);
        exp_q.delete(j);
      end
    end
    total++;
    if (wrA === 1'b1 && wrB === 1'b1 && addrA === addrB) begin
      bad++;
      $display("FAIL write_collision: both ports write addr %h at cycle %0d, required distinct", addrA, cyc);
    end
  end

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] w,
                       input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
  endtask

  task automatic commit(input logic [NR-1:0] granted);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (granted[i] && !req_wr[i])
        exp_q.push_back('{id: i, data: model_mem[req_addr[i*AW +: AW]], due: cyc + 1});
    for (int i = 0; i < NR; i++)
      if (granted[i] && req_wr[i])
        model_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
  endtask

  task automatic drain();
    req_valid = '0;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    pulse_reset();
    @(negedge clk);
    total++;
    if (wrA !== 1'b0 || wrB !== 1'b0) begin
      bad++;
      $display("FAIL reset_wr: wrA=%b wrB=%b, required 0 0", wrA, wrB);
    end
    total++;
    if (addrA !== 4'h0 || addrB !== 4'h0) begin
      bad++;
      $display("FAIL reset_addr: addrA=%h addrB=%h, required 0 0", addrA, addrB);
    end
    total++;
    if (rsp_valid !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rsp_valid: got %b, required 0000", rsp_valid);
    end
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: got %b, required 0000", req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
    drive(4'b0001, 4'b0001, 16'h0001, 32'h0000_00A1);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL wr0_ready: got %b, required 0001", req_ready);
    end
    commit(4'b0001);
    total++;
    if (wrA !== 1'b1 || addrA !== 4'h1 || dataA_in !== 8'hA1 || wrB !== 1'b0) begin
      bad++;
      $display("FAIL wr0_cmd: wrA=%b addrA=%h dataA=%h wrB=%b, required 1 1 a1 0", wrA, addrA, dataA_in, wrB);
    end
    drive(4'b0001, 4'b0000, 16'h0001, 32'h0);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rd0_ready: got %b, required 0001", req_ready);
    end
    commit(4'b0001);
    drain();
    total++;
    if (rsp_cnt[0] != 1) begin
      bad++;
      $display("FAIL rd0_count: got %0d responses, required 1", rsp_cnt[0]);
    end
  endtask

  task automatic test_dual_write();
    drive(4'b0110, 4'b0110, 16'h0540, 32'h00E5_D400);
    total++;
    if (req_ready !== 4'b0110) begin
      bad++;
      $display("FAIL dual_wr_ready: got %b, required 0110", req_ready);
    end
    commit(4'b0110);
    total++;
    if (wrA !== 1'b1 || addrA !== 4'h4 || dataA_in !== 8'hD4 ||
        wrB !== 1'b1 || addrB !== 4'h5 || dataB_in !== 8'hE5) begin
      bad++;
      $display("FAIL dual_wr_cmd: A=%b/%h/%h B=%b/%h/%h, required 1/4/d4 1/5/e5",
               wrA, addrA, dataA_in, wrB, addrB, dataB_in);
    end
    drive(4'b0110, 4'b0000, 16'h0540, 32'h0);
    total++;
    if (req_ready !== 4'b0110) begin
      bad++;
      $display("FAIL dual_rd_ready: got %b, required 0110", req_ready);
    end
    commit(4'b0110);
    drain();
  endtask

  task automatic test_conflict();
    drive(4'b1001, 4'b1001, 16'h6006, 32'h6300_0060);
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL conflict_first_ready: got %b, required 1000", req_ready);
    end
    commit(4'b1000);
    total++;
    if (wrA !== 1'b1 || addrA !== 4'h6 || dataA_in !== 8'h63 || wrB !== 1'b0) begin
      bad++;
      $display("FAIL conflict_first_cmd: wrA=%b addrA=%h dataA=%h wrB=%b, required 1 6 63 0", wrA, addrA, dataA_in, wrB);
    end
    drive(4'b0001, 4'b0001, 16'h6006, 32'h6300_0060);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL conflict_second_ready: got %b, required 0001", req_ready);
    end
    commit(4'b0001);
    req_valid = '0;
    @(posedge clk);
    #1;
    total++;
    if (ram_mem[6] !== 8'h60) begin
      bad++;
      $display("FAIL conflict_mem6: got %h, required 60", ram_mem[6]);
    end
    drive(4'b0010, 4'b0000, 16'h0060, 32'h0);
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL conflict_rd_ready: got %b, required 0010", req_ready);
    end
    commit(4'b0010);
    drain();
  endtask

  task automatic test_rotation();
    logic [NR-1:0] exp_rdy;
    pulse_reset();
    for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      drive(4'b1111, 4'b0000, 16'h6541, 32'h0);
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rotation_ready c=%0d: got %b, required %b", c, req_ready, exp_rdy);
      end
      commit(exp_rdy);
    end
    drain();
    for (int i = 0; i < NR; i++) begin
      total++;
      if (rsp_cnt[i] != 4) begin
        bad++;
        $display("FAIL rotation_count id=%0d: got %0d, required 4", i, rsp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    drive(4'b0100, 4'b0000, 16'h0500, 32'h0);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL flush_ready: got %b, required 0100", req_ready);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 4'b0000) begin
        bad++;
        $display("FAIL flush_rsp n=%0d: got %b, required 0000", n, rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    drive(4'b1100, 4'b0000, 16'h6500, 32'h0);
    total++;
    if (req_ready !== 4'b1100) begin
      bad++;
      $display("FAIL flush_after_ready: got %b, required 1100", req_ready);
    end
    commit(4'b1100);
    total++;
    if (addrA !== 4'h5 || addrB !== 4'h6) begin
      bad++;
      $display("FAIL flush_rr_restart: addrA=%h addrB=%h, required 5 6", addrA, addrB);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_conflict();
    test_rotation();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
